// File: rtl/quotient_bcd_conv.sv
// Serial double-dabble binary-to-BCD converter for the divider quotient.
// Latency: N cycles from the accept edge to out_valid; next accept no sooner than N+2 cycles.
// Backpressure: the result is held in DONE until out_ready; in_ready is only high in IDLE.
module quotient_bcd_conv #(
    parameter int N      = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic                  busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    sr_q, sr_d;
    logic [BW-1:0]   acc_q, acc_d;
    logic [BW-1:0]   acc_adj;
    logic            sticky_q, sticky_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;

    // Pre-shift correction: any digit of 5 or more would exceed 9 after doubling.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d     = bin;
                    acc_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CW'(N);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // A bit leaving the top digit means the value needs more digits than we keep.
                acc_d    = {acc_adj[BW-2:0], sr_q[N-1]};
                sr_d     = sr_q << 1;
                sticky_d = sticky_q | acc_adj[BW-1];
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = acc_d;
                    ovf_d   = sticky_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign bcd       = bcd_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_quotient_bcd_conv.sv
// Scoreboard bench for quotient_bcd_conv: a two-digit instance and a one-digit (undersized) instance.
module tb_quotient_bcd_conv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic [5:0] bin = '0;
    logic       in_ready, out_valid, overflow, busy;
    logic [7:0] bcd;

    logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic [5:0] bin1 = '0;
    logic       in_ready1, out_valid1, overflow1, busy1;
    logic [3:0] bcd1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [8:0] sb[$];
    logic [8:0] sb1[$];

    always #5 clk = ~clk;

    quotient_bcd_conv #(.N(6), .DIGITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .overflow(overflow), .busy(busy)
    );

    quotient_bcd_conv #(.N(6), .DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .bin(bin1),
        .out_valid(out_valid1), .out_ready(out_ready1), .bcd(bcd1), .overflow(overflow1), .busy(busy1)
    );

    // Reference: {overflow, low DIGITS decimal digits as packed BCD}.
    function automatic logic [8:0] model(input int v, input int d);
        int p, m;
        logic [7:0] r;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        m = v % p;
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {(v >= p), r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int v);
        for (int k = 0; k < 40 && !in_ready; k++) tick();
        in_valid = 1'b1;
        bin = 6'(v);
        tick();
        in_valid = 1'b0;
        sb.push_back(model(v, 2));
    endtask

    task automatic send1(input int v);
        for (int k = 0; k < 40 && !in_ready1; k++) tick();
        in_valid1 = 1'b1;
        bin1 = 6'(v);
        tick();
        in_valid1 = 1'b0;
        sb1.push_back(model(v, 1));
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_out1(output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (out_valid1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({in_ready, out_valid, busy, overflow, bcd} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b busy=%b ovf=%b bcd=%h want rdy=1 vld=0 busy=0 ovf=0 bcd=00",
                     in_ready, out_valid, busy, overflow, bcd);
        end
        checks++;
        if ({in_ready1, out_valid1, busy1, overflow1, bcd1} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_state_d1 got rdy=%b vld=%b busy=%b ovf=%b bcd=%h",
                     in_ready1, out_valid1, busy1, overflow1, bcd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        logic [8:0] exp;
        out_ready = 1'b1;
        send(3);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got busy=%b rdy=%b want busy=1 rdy=0", busy, in_ready);
        end
        wait_out(lat);
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL basic_latency got %0d want 6", lat);
        end
        exp = sb.pop_front();
        checks++;
        if ({overflow, bcd} !== exp) begin
            errors++;
            $display("FAIL basic_result got ovf=%b bcd=%h want ovf=%b bcd=%h", overflow, bcd, exp[8], exp[7:0]);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_return_idle got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int lat, c0, c1;
        logic [8:0] exp;
        out_ready = 1'b1;
        in_valid = 1'b1;
        bin = 6'd63;
        tick();
        c0 = cyc;
        sb.push_back(model(63, 2));
        bin = 6'd0;
        wait_out(lat);
        exp = sb.pop_front();
        checks++;
        if (lat !== 6 || {overflow, bcd} !== exp) begin
            errors++;
            $display("FAIL b2b_first got lat=%0d ovf=%b bcd=%h want lat=6 ovf=%b bcd=%h",
                     lat, overflow, bcd, exp[8], exp[7:0]);
        end
        tick();
        tick();
        c1 = cyc;
        sb.push_back(model(0, 2));
        in_valid = 1'b0;
        checks++;
        if (c1 - c0 !== 8 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_spacing got %0d cycles busy=%b want 8 busy=1", c1 - c0, busy);
        end
        wait_out(lat);
        exp = sb.pop_front();
        checks++;
        if (lat !== 6 || {overflow, bcd} !== exp) begin
            errors++;
            $display("FAIL b2b_second got lat=%0d ovf=%b bcd=%h want lat=6 ovf=%b bcd=%h",
                     lat, overflow, bcd, exp[8], exp[7:0]);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [8:0] exp;
        out_ready = 1'b0;
        send(2);
        wait_out(lat);
        exp = sb.pop_front();
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL bp_latency got %0d want 6", lat);
        end
        in_valid = 1'b1;
        bin = 6'd50;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {overflow, bcd} !== exp) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got vld=%b rdy=%b ovf=%b bcd=%h want vld=1 rdy=0 ovf=%b bcd=%h",
                         k, out_valid, in_ready, overflow, bcd, exp[8], exp[7:0]);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || {overflow, bcd} !== exp) begin
            errors++;
            $display("FAIL bp_release got vld=%b bcd=%h want vld=1 bcd=%h", out_valid, bcd, exp[7:0]);
        end
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_not_captured got rdy=%b busy=%b vld=%b want rdy=1 busy=0 vld=0",
                     in_ready, busy, out_valid);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [8:0] exp;
        out_ready = 1'b1;
        send(45);
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_busy got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, overflow, bcd} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL abort_async got rdy=%b vld=%b busy=%b ovf=%b bcd=%h want rdy=1 vld=0 busy=0 ovf=0 bcd=00",
                     in_ready, out_valid, busy, overflow, bcd);
        end
        #1;
        rst_n = 1'b1;
        sb.delete();
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_partial got busy=%b vld=%b want 0 0", busy, out_valid);
        end
        send(45);
        wait_out(lat);
        exp = sb.pop_front();
        checks++;
        if (lat !== 6 || {overflow, bcd} !== exp) begin
            errors++;
            $display("FAIL abort_retry got lat=%0d ovf=%b bcd=%h want lat=6 ovf=%b bcd=%h",
                     lat, overflow, bcd, exp[8], exp[7:0]);
        end
        tick();
    endtask

    task automatic test_overflow();
        int lat;
        logic [8:0] exp;
        int vals[2] = '{42, 9};
        out_ready1 = 1'b1;
        foreach (vals[i]) begin
            send1(vals[i]);
            wait_out1(lat);
            exp = sb1.pop_front();
            checks++;
            if (lat !== 6 || {overflow1, 4'h0, bcd1} !== exp) begin
                errors++;
                $display("FAIL ovf_bin%0d got lat=%0d ovf=%b bcd=%h want lat=6 ovf=%b bcd=%h",
                         vals[i], lat, overflow1, bcd1, exp[8], exp[3:0]);
            end
            tick();
        end
    endtask

    task automatic test_sweep();
        int lat;
        logic [8:0] exp;
        out_ready = 1'b1;
        for (int v = 0; v < 64; v++) begin
            send(v);
            wait_out(lat);
            exp = sb.pop_front();
            checks++;
            if (lat !== 6 || {overflow, bcd} !== exp) begin
                errors++;
                $display("FAIL sweep_%0d got lat=%0d ovf=%b bcd=%h want lat=6 ovf=%b bcd=%h",
                         v, lat, overflow, bcd, exp[8], exp[7:0]);
            end
            checks++;
            if (bcd[3:0] > 4'd9 || bcd[7:4] > 4'd9) begin
                errors++;
                $display("FAIL sweep_digit_%0d got bcd=%h want each digit <= 9", v, bcd);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        test_overflow();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
